// File: rtl/pwm_regs_pkg.sv
// Register map and widths for the PWM bank; shared with the SPI peripheral stage.
package pwm_regs_pkg;
  localparam int REG_W  = 8;
  localparam int ADDR_W = 7;

  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [ADDR_W-1:0] ADDR_DUTY      = 7'h04;
  localparam logic [ADDR_W-1:0] MAX_ADDR       = 7'h04;

  function automatic logic addr_in_map(input logic [ADDR_W-1:0] addr);
    return addr <= MAX_ADDR;
  endfunction
endpackage

// File: rtl/pwm_tick_gen.sv
// Prescaler plus 8-bit PWM period counter; flags the wrap edge and pulses period_start after it.
module pwm_tick_gen #(
  parameter int CLK_DIV = 13
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] pwm_cnt,
  output logic       wrap,
  output logic       period_start
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  assign tick = (div_cnt == DIV_LAST);
  assign wrap = tick && (pwm_cnt == 8'hFF);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt      <= '0;
      pwm_cnt      <= '0;
      period_start <= 1'b0;
    end else begin
      div_cnt      <= tick ? '0 : div_cnt + 1'b1;
      period_start <= wrap;
      if (tick) pwm_cnt <= pwm_cnt + 8'd1;
    end
  end
endmodule

// File: rtl/pwm_channel_bank.sv
// Register bank and 16-channel PWM output stage.
// Define PWM_DUTY_SHADOW_EN to double-buffer the duty register (new duty applies at period wrap).
module pwm_channel_bank
  import pwm_regs_pkg::*;
#(
  parameter int CLK_DIV = 13,
  parameter int NUM_CH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [REG_W-1:0]  wr_data,
  output logic              wr_err,
  output logic              period_start,
  output logic [NUM_CH-1:0] pwm_out
);
  logic [NUM_CH-1:0] en_out;
  logic [NUM_CH-1:0] en_pwm;
  logic [REG_W-1:0]  duty_active;
  logic [7:0]        pwm_cnt;
  logic              wrap;
  logic              accept;
  logic              pwm_sig;
  logic [NUM_CH-1:0] out_next;

  pwm_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
    .clk          (clk),
    .rst          (rst),
    .pwm_cnt      (pwm_cnt),
    .wrap         (wrap),
    .period_start (period_start)
  );

  assign wr_ready = ~rst;
  assign accept   = wr_valid && wr_ready;

`ifdef PWM_DUTY_SHADOW_EN
  logic [REG_W-1:0] duty_shadow;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_out      <= '0;
      en_pwm      <= '0;
      duty_active <= '0;
      wr_err      <= 1'b0;
`ifdef PWM_DUTY_SHADOW_EN
      duty_shadow <= '0;
`endif
    end else begin
      wr_err <= accept && !addr_in_map(wr_addr);
`ifdef PWM_DUTY_SHADOW_EN
      // A write landing on the wrap edge is seen only at the following wrap.
      if (wrap) duty_active <= duty_shadow;
`endif
      if (accept) begin
        case (wr_addr)
          ADDR_EN_OUT_LO: en_out[7:0]  <= wr_data;
          ADDR_EN_OUT_HI: en_out[15:8] <= wr_data;
          ADDR_EN_PWM_LO: en_pwm[7:0]  <= wr_data;
          ADDR_EN_PWM_HI: en_pwm[15:8] <= wr_data;
`ifdef PWM_DUTY_SHADOW_EN
          ADDR_DUTY:      duty_shadow  <= wr_data;
`else
          ADDR_DUTY:      duty_active  <= wr_data;
`endif
          default: ;
        endcase
      end
    end
  end

  // 0xFF is special-cased so full duty is a solid high rather than 255/256.
  assign pwm_sig = (duty_active == 8'hFF) || (pwm_cnt < duty_active);

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign out_next[gi] = en_out[gi] & (en_pwm[gi] ? pwm_sig : 1'b1);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pwm_out <= '0;
    else     pwm_out <= out_next;
  end
endmodule

// File: tb/tb_pwm_channel_bank.sv
// Directed self-checking bench for pwm_channel_bank (CLK_DIV = 13, period 3328 clocks).
module tb_pwm_channel_bank;
  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid;
  logic        wr_ready;
  logic [6:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        wr_err;
  logic        period_start;
  logic [15:0] pwm_out;

  int checks   = 0;
  int failures = 0;

  pwm_channel_bank #(.CLK_DIV(13), .NUM_CH(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_err       (wr_err),
    .period_start (period_start),
    .pwm_out      (pwm_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one write; returns #1 after the accepting edge.
  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic wait_ps(output bit ok);
    int n;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 4000) begin
      step();
      n++;
      if (period_start) ok = 1'b1;
    end
  endtask

  // Counts edges from reset release to the first period_start; also counts nonzero pwm_out samples.
  task automatic wait_first_ps(output int edges, output int nonzero);
    bit seen;
    seen    = 1'b0;
    edges   = 0;
    nonzero = 0;
    while (!seen && edges < 4000) begin
      step();
      edges++;
      if (pwm_out !== 16'h0000) nonzero++;
      if (period_start) seen = 1'b1;
    end
  endtask

  // Writes duty, syncs to a wrap, then samples exactly one full period of pwm_out.
  task automatic measure(input logic [7:0] d, output int hi, output int falls,
                         output int other_bad, output int ps_cnt, output bit ok);
    logic prev;
    wr(7'h04, d);
    wait_ps(ok);
    step();
    hi = 0; falls = 0; other_bad = 0; ps_cnt = 0;
    prev = pwm_out[0];
    for (int k = 0; k < 3328; k++) begin
      if (pwm_out[0] === 1'b1) hi++;
      if (prev === 1'b1 && pwm_out[0] === 1'b0) falls++;
      if (pwm_out[15:1] !== 15'h7FFF) other_bad++;
      if (period_start) ps_cnt++;
      prev = pwm_out[0];
      step();
    end
  endtask

  initial begin
    int  edges, nonzero, hi, falls, other_bad, ps_cnt, hi1, hi2;
    bit  ok;

    rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pwm_out", pwm_out, 16'h0000);
    chk("reset_wr_ready", wr_ready, 1'b0);
    chk("reset_period_start", period_start, 1'b0);
    chk("reset_wr_err", wr_err, 1'b0);

    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_after_release", wr_ready, 1'b1);
    wait_first_ps(edges, nonzero);
    chk("first_period_start_edges", edges, 3328);
    chk("idle_pwm_out_zero", nonzero, 0);

    // Enable-only outputs and two-edge latency
    wr(7'h00, 8'hA5);
    wr(7'h01, 8'h3C);
    chk("latency_after_e0", pwm_out, 16'h00A5);
    step();
    chk("latency_after_e1", pwm_out, 16'h3CA5);

    // Back-to-back writes, last one to an address wins
    wr(7'h00, 8'h11);
    wr(7'h00, 8'hFF);
    wr(7'h01, 8'hFF);
    step();
    chk("back_to_back", pwm_out, 16'hFFFF);

    // Out-of-map addresses
    wr(7'h05, 8'h00);
    chk("err_addr05_pulse", wr_err, 1'b1);
    step();
    chk("err_addr05_clear", wr_err, 1'b0);
    wr(7'h7F, 8'h00);
    chk("err_addr7f_pulse", wr_err, 1'b1);
    wr(7'h04, 8'h00);
    chk("valid_addr_no_err", wr_err, 1'b0);
    step();
    chk("regs_unchanged_after_err", pwm_out, 16'hFFFF);

    // PWM on channel 0 only
    wr(7'h02, 8'h01);
    wr(7'h03, 8'h00);
    measure(8'h80, hi, falls, other_bad, ps_cnt, ok);
    chk("duty80_sync", ok, 1'b1);
    chk("duty80_high", hi, 1664);
    chk("duty80_one_pulse", falls, 1);
    chk("duty80_other_ch", other_bad, 0);
    chk("duty80_period", ps_cnt, 1);
    measure(8'h00, hi, falls, other_bad, ps_cnt, ok);
    chk("duty00_high", hi, 0);
    chk("duty00_other_ch", other_bad, 0);
    measure(8'hFF, hi, falls, other_bad, ps_cnt, ok);
    chk("dutyFF_high", hi, 3328);
    chk("dutyFF_other_ch", other_bad, 0);

    // Duty change 0x40 -> 0xC0 mid-period (cnt ~100)
    wr(7'h04, 8'h40);
    wait_ps(ok);
    chk("shadow_sync", ok, 1'b1);
    step();
    hi1 = 0; hi2 = 0;
    for (int k = 0; k < 6656; k++) begin
      if (pwm_out[0] === 1'b1) begin
        if (k < 3328) hi1++;
        else          hi2++;
      end
      if (k == 1300) wr(7'h04, 8'hC0);
      else           step();
    end
`ifdef PWM_DUTY_SHADOW_EN
    chk("change_period1_high", hi1, 832);
`else
    chk("change_period1_high", hi1, 2026);
`endif
    chk("change_period2_high", hi2, 2496);

    // Asynchronous reset mid-period with outputs high
    @(posedge clk);
    #2;
    chk("pre_reset_high", pwm_out[15:1], 15'h7FFF);
    rst = 1'b1;
    #1;
    chk("async_reset_pwm_out", pwm_out, 16'h0000);
    chk("async_reset_ready", wr_ready, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_first_ps(edges, nonzero);
    chk("restart_period_start_edges", edges, 3328);
    chk("regs_cleared", nonzero, 0);
    wr(7'h00, 8'hFF);
    wr(7'h01, 8'hFF);
    wr(7'h02, 8'h01);
    step();
    chk("duty_cleared_by_reset", pwm_out, 16'hFFFE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
